lcd_img_ctrl_param: RTL and testbench

// Parametrised image-processing controller; next generation of the 8x8 LCD controller.

---
 rtl/lcd_img_ctrl_param.sv | 251 +++++++++++++++++++++++++
 tb/tb_lcd_img_ctrl_param.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_img_ctrl_param.sv
// lcd_img_ctrl_param: parametrised W x H image controller.
// Loads an image from IROM into an internal buffer, applies 2x2-window
// commands around a movable operation point, and streams the buffer to IRAM
// on a write command. Returns to command mode after every write or reload.
//
// Command handshake: cmd/cmd_valid are sampled on a rising edge only while
// busy=0 (state CMD); a request seen while busy=1 is dropped, never queued.
// busy rises in the cycle after acceptance and stays high until the command
// has finished.
module lcd_img_ctrl_param #(
  parameter int DW    = 8,
  parameter int AW    = 6,
  parameter int LOG_W = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    cmd,
  input  logic          cmd_valid,
  input  logic [DW-1:0] IROM_Q,
  output logic          IROM_rd,
  output logic [AW-1:0] IROM_A,
  output logic          IRAM_valid,
  output logic [DW-1:0] IRAM_D,
  output logic [AW-1:0] IRAM_A,
  output logic          busy,
  output logic          done,
  output logic [2:0]    dbg_state
);

  localparam int N  = 1 << AW;
  localparam int YW = AW - LOG_W;
  localparam int W  = 1 << LOG_W;
  localparam int H  = 1 << YW;

  localparam logic [LOG_W-1:0] X_MIN  = LOG_W'(1);
  localparam logic [LOG_W-1:0] X_MAX  = '1;
  localparam logic [LOG_W-1:0] X_INIT = LOG_W'(W / 2);
  localparam logic [YW-1:0]    Y_MIN  = YW'(1);
  localparam logic [YW-1:0]    Y_MAX  = '1;
  localparam logic [YW-1:0]    Y_INIT = YW'(H / 2);
  localparam logic [AW-1:0]    LAST   = '1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_CMD   = 3'd2;
  localparam logic [2:0] S_EXE   = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [3:0]       cmd_q, cmd_d;
  logic [LOG_W-1:0] x_q, x_d;
  logic [YW-1:0]    y_q, y_d;
  logic             iram_valid_q, iram_valid_d;
  logic [AW-1:0]    iram_a_q, iram_a_d;
  logic [DW-1:0]    iram_d_q, iram_d_d;
  logic             done_q, done_d;
  logic [DW-1:0]    mem_q [N];
  logic [DW-1:0]    mem_d [N];

  // Window addresses and pixel values around the current point.
  logic [LOG_W-1:0] xm1;
  logic [YW-1:0]    ym1;
  logic [AW-1:0]    a1, a2, a3, a4;
  logic [DW-1:0]    p1, p2, p3, p4;
  logic [DW-1:0]    mx12, mx34, mx_all, mn12, mn34, mn_all;
  logic [DW+1:0]    sum4;
  logic [DW-1:0]    avg4;
  logic [DW-1:0]    n1, n2, n3, n4;
  logic             win_we, rd_we;

  // Window geometry and the reductions the window commands draw on.
  always_comb begin
    xm1    = x_q - LOG_W'(1);
    ym1    = y_q - YW'(1);
    a1     = {ym1, xm1};
    a2     = {ym1, x_q};
    a3     = {y_q, xm1};
    a4     = {y_q, x_q};
    p1     = mem_q[a1];
    p2     = mem_q[a2];
    p3     = mem_q[a3];
    p4     = mem_q[a4];
    mx12   = (p1 > p2) ? p1 : p2;
    mx34   = (p3 > p4) ? p3 : p4;
    mx_all = (mx12 > mx34) ? mx12 : mx34;
    mn12   = (p1 < p2) ? p1 : p2;
    mn34   = (p3 < p4) ? p3 : p4;
    mn_all = (mn12 < mn34) ? mn12 : mn34;
    sum4   = {2'b00, p1} + {2'b00, p2} + {2'b00, p3} + {2'b00, p4};
    avg4   = sum4[DW+1:2];
  end

  // Control FSM: next state, counter, point moves and window results.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cmd_d        = cmd_q;
    x_d          = x_q;
    y_d          = y_q;
    iram_valid_d = 1'b0;
    iram_a_d     = iram_a_q;
    iram_d_d     = iram_d_q;
    done_d       = 1'b0;
    win_we       = 1'b0;
    rd_we        = 1'b0;
    n1           = p1;
    n2           = p2;
    n3           = p3;
    n4           = p4;
    case (state_q)
      S_IDLE: begin
        state_d = S_READ;
        cnt_d   = '0;
      end
      S_READ: begin
        rd_we = 1'b1;
        if (cnt_q == LAST) begin
          state_d = S_CMD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      S_CMD: begin
        if (cmd_valid) begin
          cmd_d   = cmd;
          cnt_d   = '0;
          state_d = (cmd == 4'd0) ? S_WRITE : S_EXE;
        end
      end
      S_EXE: begin
        state_d = S_CMD;
        case (cmd_q)
          4'd1: if (y_q != Y_MIN) y_d = y_q - YW'(1);
          4'd2: if (y_q != Y_MAX) y_d = y_q + YW'(1);
          4'd3: if (x_q != X_MIN) x_d = x_q - LOG_W'(1);
          4'd4: if (x_q != X_MAX) x_d = x_q + LOG_W'(1);
          4'd5: begin
            win_we = 1'b1;
            n1 = mx_all; n2 = mx_all; n3 = mx_all; n4 = mx_all;
          end
          4'd6: begin
            win_we = 1'b1;
            n1 = mn_all; n2 = mn_all; n3 = mn_all; n4 = mn_all;
          end
          4'd7: begin
            win_we = 1'b1;
            n1 = avg4; n2 = avg4; n3 = avg4; n4 = avg4;
          end
          4'd8: begin
            win_we = 1'b1;
            n1 = p2; n2 = p4; n3 = p1; n4 = p3;
          end
          4'd9: begin
            win_we = 1'b1;
            n1 = p3; n2 = p1; n3 = p4; n4 = p2;
          end
          4'd10: begin
            win_we = 1'b1;
            n1 = p3; n2 = p4; n3 = p1; n4 = p2;
          end
          4'd11: begin
            win_we = 1'b1;
            n1 = p2; n2 = p1; n3 = p4; n4 = p3;
          end
          4'd12: begin
            win_we = 1'b1;
            n1 = ~p1; n2 = ~p2; n3 = ~p3; n4 = ~p4;
          end
          4'd13: begin
            state_d = S_READ;
            cnt_d   = '0;
          end
          default: ;
        endcase
      end
      S_WRITE: begin
        iram_valid_d = 1'b1;
        iram_a_d     = cnt_q;
        iram_d_d     = mem_q[cnt_q];
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_CMD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Buffer update: ROM load in READ, four window writes in EXE.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      mem_d[i] = mem_q[i];
      if (rd_we && cnt_q == AW'(i)) mem_d[i] = IROM_Q;
      if (win_we) begin
        if (a1 == AW'(i)) mem_d[i] = n1;
        if (a2 == AW'(i)) mem_d[i] = n2;
        if (a3 == AW'(i)) mem_d[i] = n3;
        if (a4 == AW'(i)) mem_d[i] = n4;
      end
    end
  end

  // Control and output registers; reset aborts any load or write at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      cmd_q        <= '0;
      x_q          <= X_INIT;
      y_q          <= Y_INIT;
      iram_valid_q <= 1'b0;
      iram_a_q     <= '0;
      iram_d_q     <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cmd_q        <= cmd_d;
      x_q          <= x_d;
      y_q          <= y_d;
      iram_valid_q <= iram_valid_d;
      iram_a_q     <= iram_a_d;
      iram_d_q     <= iram_d_d;
      done_q       <= done_d;
    end
  end

  // Image buffer; contents are meaningless until the first load completes.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign IROM_rd    = (state_q == S_READ);
  assign IROM_A     = IROM_rd ? cnt_q : '0;
  assign IRAM_valid = iram_valid_q;
  assign IRAM_A     = iram_a_q;
  assign IRAM_D     = iram_d_q;
  assign busy       = (state_q != S_CMD);
  assign done       = done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_lcd_img_ctrl_param.sv
// Directed bench for lcd_img_ctrl_param: an 8x8 instance for the full command
// set and a 16x16 instance for the larger geometry.
module tb_lcd_img_ctrl_param;

  logic       clk;
  // 8x8 instance
  logic       reset, cmd_valid, irom_rd, iram_valid, busy, done;
  logic [3:0] cmd;
  logic [7:0] irom_q, iram_d;
  logic [5:0] irom_a, iram_a;
  logic [2:0] dbg_state;
  // 16x16 instance
  logic       reset_b, cmd_valid_b, irom_rd_b, iram_valid_b, busy_b, done_b;
  logic [3:0] cmd_b;
  logic [7:0] irom_q_b, iram_d_b, irom_a_b, iram_a_b;
  logic [2:0] dbg_state_b;

  logic [7:0]  rom_a [64];
  logic [7:0]  ram_a [64];
  logic [7:0]  rom_b [256];
  logic [7:0]  ram_b [256];
  logic [13:0] exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int busy_cyc, done_cnt, valid_at_done;

  assign irom_q   = rom_a[irom_a];
  assign irom_q_b = rom_b[irom_a_b];

  lcd_img_ctrl_param #(.DW(8), .AW(6), .LOG_W(3)) u_dut (
    .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid),
    .IROM_Q(irom_q), .IROM_rd(irom_rd), .IROM_A(irom_a),
    .IRAM_valid(iram_valid), .IRAM_D(iram_d), .IRAM_A(iram_a),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  lcd_img_ctrl_param #(.DW(8), .AW(8), .LOG_W(4)) u_dut_b (
    .clk(clk), .reset(reset_b), .cmd(cmd_b), .cmd_valid(cmd_valid_b),
    .IROM_Q(irom_q_b), .IROM_rd(irom_rd_b), .IROM_A(irom_a_b),
    .IRAM_valid(iram_valid_b), .IRAM_D(iram_d_b), .IRAM_A(iram_a_b),
    .busy(busy_b), .done(done_b), .dbg_state(dbg_state_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // scoreboard: capture every IRAM write, compare in order against exp_q
  always @(negedge clk) begin
    if (iram_valid) begin
      ram_a[iram_a] = iram_d;
      if (exp_q.size() > 0) check("iram_stream", {18'd0, iram_a, iram_d}, {18'd0, exp_q.pop_front()});
    end
    if (iram_valid_b) ram_b[iram_a_b] = iram_d_b;
  end

  // driver tasks
  task automatic wait_ready(input int budget);
    int ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
    end
    check("ready_timeout", ok, 1);
  endtask

  task automatic send_cmd(input logic [3:0] c);
    wait_ready(200);
    cmd = c;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic repeat_cmd(input logic [3:0] c, input int n);
    for (int i = 0; i < n; i++) send_cmd(c);
  endtask

  // issue a write and watch it: busy cycles, done pulses, IRAM_valid at done
  task automatic write_frame(input bit hold);
    int ended = 0;
    busy_cyc = 0; done_cnt = 0; valid_at_done = 0;
    send_cmd(4'd0);
    if (hold) begin cmd = 4'd5; cmd_valid = 1'b1; end
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done) begin done_cnt++; if (iram_valid) valid_at_done = 1; end
      if (!busy) begin cmd_valid = 1'b0; ended = 1; break; end
      busy_cyc++;
    end
    check("write_timeout", ended, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
  endtask

  task automatic reload_rom_identity();
    for (int k = 0; k < 64; k++) rom_a[k] = 8'(k);
  endtask

  initial begin
    reset = 1'b1; cmd = '0; cmd_valid = 1'b0;
    reset_b = 1'b1; cmd_b = '0; cmd_valid_b = 1'b0;
    reload_rom_identity();
    for (int k = 0; k < 256; k++) rom_b[k] = 8'(255 - k);

    // reset values
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1);
    check("rst_done", done, 0);
    check("rst_rom_rd", irom_rd, 0);
    check("rst_rom_a", irom_a, 0);
    check("rst_iram_valid", iram_valid, 0);
    check("rst_iram_d", iram_d, 0);
    check("rst_iram_a", iram_a, 0);
    check("rst_state", dbg_state, 0);
    reset = 1'b0;
    @(negedge clk);
    check("read_rd_k0", irom_rd, 1);
    check("read_a_k0", irom_a, 0);
    @(negedge clk);
    check("read_a_k1", irom_a, 1);
    wait_ready(200);

    // 1: plain write of ROM[k]=k
    for (int k = 0; k < 64; k++) exp_q.push_back({6'(k), 8'(k)});
    write_frame(0);
    check("w1_busy_cycles", busy_cyc, 65);
    check("w1_done_pulses", done_cnt, 1);
    check("w1_valid_at_done", valid_at_done, 0);
    check("w1_sb_empty", exp_q.size(), 0);
    check("w1_busy_after", busy, 0);

    // 2: left/up clamp to (1,1), max on 0,1,8,9
    repeat_cmd(4'd3, 5);
    repeat_cmd(4'd1, 5);
    send_cmd(4'd5);
    write_frame(0);
    check("max_a0", ram_a[0], 9);
    check("max_a1", ram_a[1], 9);
    check("max_a8", ram_a[8], 9);
    check("max_a9", ram_a[9], 9);
    check("max_a2", ram_a[2], 2);
    check("max_a16", ram_a[16], 16);

    // 3: reload new ROM, move to (4,4), cw / ccw / mirrors
    rom_a[27] = 8'd10; rom_a[28] = 8'd20; rom_a[35] = 8'd30; rom_a[36] = 8'd40;
    send_cmd(4'd13);
    @(negedge clk);
    check("reload_busy", busy, 1);
    repeat_cmd(4'd4, 3);
    repeat_cmd(4'd2, 3);
    send_cmd(4'd9);
    write_frame(0);
    check("reload_a0", ram_a[0], 0);
    check("cw_p1", ram_a[27], 30);
    check("cw_p2", ram_a[28], 10);
    check("cw_p3", ram_a[35], 40);
    check("cw_p4", ram_a[36], 20);
    send_cmd(4'd8);
    write_frame(0);
    check("ccw_p1", ram_a[27], 10);
    check("ccw_p2", ram_a[28], 20);
    check("ccw_p3", ram_a[35], 30);
    check("ccw_p4", ram_a[36], 40);
    send_cmd(4'd10);
    send_cmd(4'd11);
    write_frame(0);
    check("mir_p1", ram_a[27], 40);
    check("mir_p2", ram_a[28], 30);
    check("mir_p3", ram_a[35], 20);
    check("mir_p4", ram_a[36], 10);

    // 4: average, saturated average, invert
    reload_rom_identity();
    rom_a[27] = 8'd1;   rom_a[28] = 8'd2;   rom_a[35] = 8'd3;   rom_a[36] = 8'd5;
    rom_a[9]  = 8'd255; rom_a[10] = 8'd255; rom_a[17] = 8'd255; rom_a[18] = 8'd255;
    rom_a[45] = 8'd0;   rom_a[46] = 8'd1;   rom_a[53] = 8'd254; rom_a[54] = 8'd255;
    send_cmd(4'd13);
    send_cmd(4'd7);
    repeat_cmd(4'd1, 2);
    repeat_cmd(4'd3, 2);
    send_cmd(4'd7);
    repeat_cmd(4'd2, 4);
    repeat_cmd(4'd4, 4);
    send_cmd(4'd12);
    send_cmd(4'd14);
    @(negedge clk);
    check("lat_busy_t1", busy, 1);
    @(negedge clk);
    check("lat_busy_t2", busy, 0);
    write_frame(0);
    check("avg_a27", ram_a[27], 2);
    check("avg_a36", ram_a[36], 2);
    check("avg_sat_a9", ram_a[9], 255);
    check("avg_sat_a18", ram_a[18], 255);
    check("inv_a45", ram_a[45], 255);
    check("inv_a46", ram_a[46], 254);
    check("inv_a53", ram_a[53], 1);
    check("inv_a54", ram_a[54], 0);
    check("inv_a44", ram_a[44], 44);

    // 5: request held during write is ignored
    write_frame(1);
    check("hold_busy_cycles", busy_cyc, 65);
    @(negedge clk);
    check("hold_state_cmd", dbg_state, 2);
    write_frame(0);
    check("hold_a45", ram_a[45], 255);
    check("hold_a54", ram_a[54], 0);

    // reset mid-write aborts at once, then a full reload from (4,4)
    send_cmd(4'd0);
    repeat (10) @(negedge clk);
    for (int k = 0; k < 64; k++) rom_a[k] = 8'(k + 100);
    reset = 1'b1;
    #1;
    check("abort_valid", iram_valid, 0);
    check("abort_busy", busy, 1);
    check("abort_rom_rd", irom_rd, 0);
    @(negedge clk);
    reset = 1'b0;
    wait_ready(200);
    send_cmd(4'd12);
    write_frame(0);
    check("rld_a0", ram_a[0], 100);
    check("rld_a63", ram_a[63], 163);
    check("rld_inv_a27", ram_a[27], 128);
    check("rld_inv_a36", ram_a[36], 119);
    check("rld_a26", ram_a[26], 126);
    check("rld_done", done_cnt, 1);

    // 6: 16x16 instance, down clamps at y=15, min on 231,232,247,248
    reset_b = 1'b0;
    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < 400; i++) begin
        @(negedge clk);
        if (!busy_b) break;
      end
      check("b_ready", busy_b, 0);
      cmd_b = (n < 10) ? 4'd2 : ((n == 10) ? 4'd6 : 4'd0);
      cmd_valid_b = 1'b1;
      @(posedge clk);
      #1 cmd_valid_b = 1'b0;
    end
    done_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done_b) begin done_cnt++; break; end
    end
    check("b_done", done_cnt, 1);
    check("b_min_a231", ram_b[231], 7);
    check("b_min_a232", ram_b[232], 7);
    check("b_min_a247", ram_b[247], 7);
    check("b_min_a248", ram_b[248], 7);
    check("b_a230", ram_b[230], 25);
    check("b_a215", ram_b[215], 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
